// File: rtl/lab62soc_keys_edge_pio.sv
// rtl/lab62soc_keys_edge_pio.sv - Avalon-MM input PIO with per-bit sync, debounce and sticky edge capture
// Debounced key/switch inputs raise a maskable level IRQ through a write-one-to-clear capture register.
module lab62soc_keys_edge_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, stable, stable_d;
  logic [WIDTH-1:0] irq_mask, edgecapture;
  logic [WIDTH-1:0] ev, cap_clr;
  logic [CW-1:0]    cnt [WIDTH];
  logic             bus_wr, mask_wr;
  logic             unused_wdata;

  assign bus_wr       = chipselect && !write_n;
  assign mask_wr      = bus_wr && (address == 2'd2);
  assign cap_clr      = (bus_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_comb begin
    ev = '0;
    case (EDGE_TYPE)
      0:       ev = stable & ~stable_d;
      1:       ev = ~stable & stable_d;
      default: ev = stable ^ stable_d;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= '0;
      sync2       <= '0;
      stable      <= '0;
      stable_d    <= '0;
      irq_mask    <= '0;
      edgecapture <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      stable_d <= stable;
      // A bit is accepted only after holding its new value for DEBOUNCE_CYCLES clocks.
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      if (mask_wr) irq_mask <= writedata[WIDTH-1:0];
      // New events override a simultaneous clear so nothing is lost.
      edgecapture <= (edgecapture & ~cap_clr) | ev;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = 32'(stable);
      2'd2:    readdata = 32'(irq_mask);
      2'd3:    readdata = 32'(edgecapture);
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irq_mask);

endmodule

// File: tb/tb_lab62soc_keys_edge_pio.sv
// tb/tb_lab62soc_keys_edge_pio.sv - self-checking bench for lab62soc_keys_edge_pio
// Two builds share the bus: falling-edge (a) and any-edge (b), both with a 4-cycle debounce.
module tb_lab62soc_keys_edge_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        cs_a = 1'b0, cs_b = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] rd_a, rd_b;
  logic [3:0]  in_a = 4'hF, in_b = 4'hF;
  logic        irq_a, irq_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lab62soc_keys_edge_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));

  lab62soc_keys_edge_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));

  typedef struct {
    logic        wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[13];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input int sel, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = (sel == 0);
    cs_b      = (sel == 1);
    tick(1);
    write_n   = 1'b1;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
  endtask

  task automatic read_a(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, rd_a, exp);
  endtask

  task automatic read_b(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, rd_b, exp);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd3, 32'h0000_0002, 2'd3, 32'h9, 1'b1};
    vecs[1]  = '{1'b1, 2'd0, 32'h0000_FFFF, 2'd3, 32'h9, 1'b1};
    vecs[2]  = '{1'b1, 2'd0, 32'h0000_FFFF, 2'd0, 32'h4, 1'b1};
    vecs[3]  = '{1'b1, 2'd1, 32'h0000_000F, 2'd1, 32'h0, 1'b1};
    vecs[4]  = '{1'b1, 2'd2, 32'hFFFF_FFF8, 2'd2, 32'h8, 1'b1};
    vecs[5]  = '{1'b1, 2'd2, 32'h0000_0002, 2'd2, 32'h2, 1'b0};
    vecs[6]  = '{1'b1, 2'd2, 32'h0000_0001, 2'd2, 32'h1, 1'b1};
    vecs[7]  = '{1'b1, 2'd3, 32'h0000_0001, 2'd3, 32'h8, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 32'h0000_0000, 2'd3, 32'h8, 1'b0};
    vecs[9]  = '{1'b1, 2'd3, 32'h0000_0000, 2'd3, 32'h8, 1'b0};
    vecs[10] = '{1'b1, 2'd2, 32'h0000_0008, 2'd2, 32'h8, 1'b1};
    vecs[11] = '{1'b1, 2'd3, 32'h0000_0008, 2'd3, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 32'h0000_0000, 2'd1, 32'h0, 1'b0};

    // Reset held with inputs high and chipselect toggling.
    for (int i = 0; i < 4; i++) begin
      cs_a = i[0];
      tick(1);
      read_a("reset_rd_a", 2'(i), 32'h0);
      check("reset_rd_b", rd_b, 32'h0);
      check("reset_irq", {31'd0, irq_a | irq_b}, 32'h0);
    end
    cs_a = 1'b0;
    reset_n = 1'b1;
    tick(5);
    read_a("rst_rel_edge5", 2'd0, 32'h0);
    tick(1);
    read_a("rst_rel_edge6", 2'd0, 32'hF);
    read_a("rst_rel_cap", 2'd3, 32'h0);
    tick(4);
    read_b("b_rise_cap", 2'd3, 32'hF);
    bus_write(1, 2'd3, 32'hF);
    read_b("b_cap_clr", 2'd3, 32'h0);
    bus_write(1, 2'd2, 32'h8);

    // Glitches of 3 cycles are rejected.
    for (int p = 0; p < 3; p++) begin
      in_a = 4'hE;
      tick(3);
      in_a = 4'hF;
      tick(3);
    end
    tick(8);
    read_a("glitch_data", 2'd0, 32'hF);
    read_a("glitch_cap", 2'd3, 32'h0);

    // Held press is accepted at edge 6, captured at edge 7; mask is 0 so no irq.
    in_a = 4'hE;
    tick(5);
    read_a("press_edge5", 2'd0, 32'hF);
    tick(1);
    read_a("press_edge6", 2'd0, 32'hE);
    read_a("press_cap6", 2'd3, 32'h0);
    tick(1);
    read_a("press_cap7", 2'd3, 32'h1);
    check("unmasked_irq", {31'd0, irq_a}, 32'h0);
    in_a = 4'hF;
    tick(8);
    read_a("release_cap", 2'd3, 32'h1);
    bus_write(0, 2'd3, 32'h1);
    read_a("clear_cap", 2'd3, 32'h0);

    // Masked press raises irq; W1C drops it on the next cycle.
    bus_write(0, 2'd2, 32'h1);
    read_a("mask_rd", 2'd2, 32'h1);
    in_a = 4'hE;
    tick(6);
    check("irq_edge6", {31'd0, irq_a}, 32'h0);
    tick(1);
    check("irq_edge7", {31'd0, irq_a}, 32'h1);
    bus_write(0, 2'd3, 32'h1);
    check("irq_cleared", {31'd0, irq_a}, 32'h0);
    read_a("irq_clr_cap", 2'd3, 32'h0);
    in_a = 4'hF;
    tick(8);

    // Event on bit 2 lands on the same edge as its clearing write.
    in_a = 4'hB;
    tick(6);
    bus_write(0, 2'd3, 32'h4);
    read_a("collision_cap", 2'd3, 32'h4);
    in_a = 4'hF;
    tick(8);
    bus_write(0, 2'd3, 32'h4);
    read_a("collision_clr", 2'd3, 32'h0);

    // Build capture = 4'hB, then run the register vector table.
    in_a = 4'h4;
    tick(7);
    read_a("cap_b", 2'd3, 32'hB);
    check("cap_b_irq", {31'd0, irq_a}, 32'h1);
    for (int v = 0; v < 13; v++) begin
      if (vecs[v].wr) bus_write(0, vecs[v].waddr, vecs[v].wdata);
      read_a($sformatf("vec%0d_rd", v), vecs[v].raddr, vecs[v].exp_rd);
      check($sformatf("vec%0d_irq", v), {31'd0, irq_a}, {31'd0, vecs[v].exp_irq});
    end

    // Any-edge build: 1->0->1 on bit 3 captures 4'h8 once, irq sticks.
    in_b = 4'h7;
    tick(6);
    read_b("b_low_cap", 2'd3, 32'h0);
    in_b = 4'hF;
    tick(1);
    read_b("b_fall_cap", 2'd3, 32'h8);
    check("b_fall_irq", {31'd0, irq_b}, 32'h1);
    tick(7);
    read_b("b_rise_data", 2'd0, 32'hF);
    read_b("b_both_cap", 2'd3, 32'h8);
    check("b_upper_zero", {4'd0, rd_b[31:4]}, 32'h0);
    check("b_sticky_irq", {31'd0, irq_b}, 32'h1);
    bus_write(1, 2'd3, 32'h8);
    read_b("b_clr_cap", 2'd3, 32'h0);
    check("b_clr_irq", {31'd0, irq_b}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
